// File: rtl/fp32_to_fixed_pipe.sv
// fp32_to_fixed_pipe
//   Streaming IEEE-754 single-precision to signed fixed-point converter.
//   y = x / 2^PRE_SHIFT - OFFSET, in Q(OUT_W-FRAC_W).FRAC_W. The output
//   saturates to the OUT_W signed range. Denormals are flushed to zero,
//   infinities saturate and NaN yields 0 with out_nan set. Three register
//   stages with a valid/ready handshake sustain one result per clock.
//
// Optional feature macro: FP2FX_ROUND_NEAREST_EN
//   defined   : magnitude rounds half away from zero after the right shift
//   undefined : magnitude truncates toward zero
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   in_valid   in   in_data valid
//   in_ready   out  block accepts in_data this cycle
//   in_data    in   [31:0] IEEE-754 single
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts this cycle
//   out_data   out  [OUT_W-1:0] signed fixed-point result
//   out_sat    out  result was clamped
//   out_nan    out  input was NaN
//   cnt_clr    in   synchronous clear of sat_cnt
//   sat_cnt    out  [CNT_W-1:0] saturated results delivered, sticks at all-ones
module fp32_to_fixed_pipe #(
  parameter int OUT_W     = 24,
  parameter int FRAC_W    = 22,
  parameter int PRE_SHIFT = 7,
  parameter int OFFSET    = 4194304,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_nan,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  // Wide enough to hold the 24-bit mantissa shifted left by up to OUT_W.
  localparam int WIDE    = OUT_W + 26;
  localparam int SH_BIAS = 127 + PRE_SHIFT - FRAC_W + 23;

  localparam logic signed [OUT_W+1:0] OFF_EXT = (OUT_W+2)'(OFFSET);
  localparam logic signed [OUT_W+1:0] MAX_V   = {3'b000, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W+1:0] MIN_V   = {3'b111, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]        MAX_O   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]        MIN_O   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX = '1;

  // Align the mantissa to the output LSB; returns {ovf, mag[OUT_W:0]}.
  // Any set bit at or above OUT_W, or a left shift beyond OUT_W, overflows.
  function automatic logic [OUT_W+1:0] shift_round(input logic [23:0]       mant,
                                                   input logic signed [9:0] sh);
    logic [WIDE-1:0] wide;
    logic [9:0]      nsh;
    logic [23:0]     rsh;
    logic            ovf;
`ifdef FP2FX_ROUND_NEAREST_EN
    logic [23:0]     rsh_m1;
`endif
    wide = '0;
    ovf  = 1'b0;
    nsh  = -sh;
    rsh  = '0;
    if (!sh[9]) begin
      if (sh > $signed(10'(OUT_W))) begin
        ovf = 1'b1;
      end else begin
        wide = {{(WIDE-24){1'b0}}, mant} << sh[5:0];
      end
    end else if (nsh < 10'd25) begin
      rsh  = mant >> nsh[4:0];
      wide = {{(WIDE-24){1'b0}}, rsh};
`ifdef FP2FX_ROUND_NEAREST_EN
      // Add the first bit shifted out: half rounds away from zero.
      rsh_m1 = mant >> (nsh[4:0] - 5'd1);
      wide   = wide + {{(WIDE-1){1'b0}}, rsh_m1[0]};
`endif
    end
    ovf = ovf | (|wide[WIDE-1:OUT_W]);
    return {ovf, wide[OUT_W:0]};
  endfunction

  // Clamp to the OUT_W signed range; returns {clamped, value}.
  function automatic logic [OUT_W:0] saturate(input logic signed [OUT_W+1:0] v);
    if (v > MAX_V) begin
      return {1'b1, MAX_O};
    end else if (v < MIN_V) begin
      return {1'b1, MIN_O};
    end else begin
      return {1'b0, v[OUT_W-1:0]};
    end
  endfunction

  // Stage registers
  logic                    vld_p0, vld_p1;
  logic                    sgn_p0, zero_p0, inf_p0, nan_p0;
  logic [23:0]             mant_p0;
  logic signed [9:0]       sh_p0;
  logic                    sgn_p1, ovf_p1, nan_p1;
  logic [OUT_W:0]          mag_p1;

  logic                    rdy1, rdy2, rdy3;
  logic signed [9:0]       sh_c;
  logic [OUT_W+1:0]        shr_c;
  logic signed [OUT_W+1:0] sv_c, v_c;
  logic [OUT_W:0]          sat_c;
  logic [OUT_W-1:0]        data_c;
  logic                    satf_c;

  assign rdy3     = !out_valid || out_ready;
  assign rdy2     = !vld_p1 || rdy3;
  assign rdy1     = !vld_p0 || rdy2;
  assign in_ready = rdy1;

  assign sh_c = $signed({2'b00, in_data[30:23]}) - $signed(10'(SH_BIAS));

  // Control: stage valids and event counter
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      sat_cnt   <= '0;
    end else begin
      if (rdy1) vld_p0    <= in_valid;
      if (rdy2) vld_p1    <= vld_p0;
      if (rdy3) out_valid <= vld_p1;
      if (cnt_clr) begin
        sat_cnt <= '0;
      end else if (out_valid && out_ready && out_sat && sat_cnt != CNT_MAX) begin
        sat_cnt <= sat_cnt + 1'b1;
      end
    end
  end

  // ---- S1: unpack and classify ----
  always_ff @(posedge clk) begin
    if (rdy1 && in_valid) begin
      sgn_p0  <= in_data[31];
      mant_p0 <= {1'b1, in_data[22:0]};
      sh_p0   <= sh_c;
      zero_p0 <= (in_data[30:23] == 8'h00);
      inf_p0  <= (in_data[30:23] == 8'hFF) && (in_data[22:0] == 23'd0);
      nan_p0  <= (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
    end
  end

  // ---- S2: align magnitude, detect overflow ----
  assign shr_c = shift_round(mant_p0, sh_p0);

  always_ff @(posedge clk) begin
    if (rdy2 && vld_p0) begin
      sgn_p1 <= sgn_p0;
      nan_p1 <= nan_p0;
      if (zero_p0 || nan_p0) begin
        mag_p1 <= '0;
        ovf_p1 <= 1'b0;
      end else begin
        mag_p1 <= shr_c[OUT_W:0];
        ovf_p1 <= shr_c[OUT_W+1] | inf_p0;
      end
    end
  end

  // ---- S3: apply sign, subtract offset, saturate ----
  always_comb begin
    sv_c   = sgn_p1 ? -$signed({1'b0, mag_p1}) : $signed({1'b0, mag_p1});
    v_c    = sv_c - OFF_EXT;
    sat_c  = saturate(v_c);
    data_c = sat_c[OUT_W-1:0];
    satf_c = sat_c[OUT_W];
    if (nan_p1) begin
      data_c = '0;
      satf_c = 1'b0;
    end else if (ovf_p1) begin
      data_c = sgn_p1 ? MIN_O : MAX_O;
      satf_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_sat  <= 1'b0;
      out_nan  <= 1'b0;
    end else if (rdy3 && vld_p1) begin
      out_data <= data_c;
      out_sat  <= satf_c;
      out_nan  <= nan_p1;
    end
  end

endmodule

// File: tb/tb_fp32_to_fixed_pipe.sv
// tb_fp32_to_fixed_pipe
//   Directed bench for fp32_to_fixed_pipe at default parameters. Expected
//   results are queued as each input is accepted and compared in order as
//   the DUT delivers them.
module tb_fp32_to_fixed_pipe;

  localparam int OUT_W = 24;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;
  logic             out_nan;
  logic             cnt_clr;
  logic [CNT_W-1:0] sat_cnt;

  always #5 clk = ~clk;

  fp32_to_fixed_pipe #(
    .OUT_W(24), .FRAC_W(22), .PRE_SHIFT(7), .OFFSET(4194304), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_nan(out_nan),
    .cnt_clr(cnt_clr), .sat_cnt(sat_cnt)
  );

  typedef struct {
    logic [23:0] data;
    logic        sat;
    logic        nan;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  logic [31:0] bp_in  [5];
  logic [23:0] bp_exp [5];
  logic        bp_sat [5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [23:0] ed, input logic es, input logic en, input int lat);
    exp_t e;
    e.data = ed;
    e.sat  = es;
    e.nan  = en;
    e.acc  = cyc;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  // Offer one input, wait (bounded) for acceptance, return at posedge+1.
  task automatic send(input logic [31:0] d, input logic [23:0] ed, input logic es,
                      input logic en, input int lat);
    int w;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 1);
    else push_exp(ed, es, en, lat);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w;
    in_valid = 1'b0;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // Output side: every transfer is matched against the head of the queue.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 0);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(mon_e.data));
        chk("out_sat", 32'(out_sat), 32'(mon_e.sat));
        chk("out_nan", 32'(out_nan), 32'(mon_e.nan));
        if (mon_e.lat >= 0) chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int w;
    bp_in  = '{32'h44000000, 32'h43000000, 32'h43800000, 32'hC3000000, 32'h3F800000};
    bp_exp = '{24'h7FFFFF, 24'h000000, 24'h400000, 24'h800000, 24'hC08000};
    bp_sat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_sat", 32'(out_sat), 0);
    chk("rst_out_nan", 32'(out_nan), 0);
    chk("rst_sat_cnt", 32'(sat_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    // Back-to-back basic conversions with latency check
    out_ready = 1'b1;
    send(32'h43000000, 24'h000000, 1'b0, 1'b0, 3);
    send(32'h43800000, 24'h400000, 1'b0, 1'b0, 3);
    send(32'h00000000, 24'hC00000, 1'b0, 1'b0, 3);
    send(32'h80000000, 24'hC00000, 1'b0, 1'b0, 3);
    send(32'h3F800000, 24'hC08000, 1'b0, 1'b0, 3);
    drain();
    chk("sat_cnt_none", 32'(sat_cnt), 0);

    // Signs, overflow, infinity, NaN
    send(32'hC3000000, 24'h800000, 1'b0, 1'b0, 3);
    drain();
    send(32'h44000000, 24'h7FFFFF, 1'b1, 1'b0, 3);
    drain();
    chk("sat_cnt_ovf", 32'(sat_cnt), 1);
    send(32'hFF800000, 24'h800000, 1'b1, 1'b0, 3);
    drain();
    chk("sat_cnt_inf", 32'(sat_cnt), 2);
    send(32'h7FC00000, 24'h000000, 1'b0, 1'b1, 3);
    drain();
    chk("sat_cnt_nan", 32'(sat_cnt), 2);

    // Clamp without magnitude overflow, both directions
    send(32'h43C00000, 24'h7FFFFF, 1'b1, 1'b0, 3);
    send(32'hC3800000, 24'h800000, 1'b1, 1'b0, 3);
    drain();
    chk("sat_cnt_clamp", 32'(sat_cnt), 4);

    // Rounding behaviour
`ifdef FP2FX_ROUND_NEAREST_EN
    send(32'h43000001, 24'h000001, 1'b0, 1'b0, 3);
`else
    send(32'h43000001, 24'h000000, 1'b0, 1'b0, 3);
`endif
    drain();

    // Backpressure: only three inputs fit while the output stalls
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 13; c++) begin
      in_valid = (idx < 5);
      in_data  = bp_in[idx < 5 ? idx : 4];
      @(negedge clk);
      if (in_valid && in_ready) begin
        push_exp(bp_exp[idx], bp_sat[idx], 1'b0, -1);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    chk("bp_accepted", 32'(idx), 3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_data", 32'(out_data), 32'h7FFFFF);
      chk("bp_hold_sat", 32'(out_sat), 1);
      chk("bp_in_ready_low", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    w = 0;
    while (idx < 5 && w < 20) begin
      in_valid = 1'b1;
      in_data  = bp_in[idx];
      @(negedge clk);
      if (in_ready) begin
        push_exp(bp_exp[idx], bp_sat[idx], 1'b0, -1);
        idx++;
      end
      @(posedge clk);
      #1;
      w++;
    end
    chk("bp_all_accepted", 32'(idx), 5);
    drain();
    chk("sat_cnt_bp_once", 32'(sat_cnt), 5);

    // Reset with three items in flight
    out_ready = 1'b0;
    send(32'h44000000, 24'h7FFFFF, 1'b1, 1'b0, -1);
    send(32'h44000000, 24'h7FFFFF, 1'b1, 1'b0, -1);
    send(32'h44000000, 24'h7FFFFF, 1'b1, 1'b0, -1);
    in_valid = 1'b0;
    reset    = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_sat_cnt", 32'(sat_cnt), 0);
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_rst_sat_cnt_after", 32'(sat_cnt), 0);
    @(posedge clk);
    #1;

    // Counter clear wins over a same-cycle saturated transfer
    send(32'h44000000, 24'h7FFFFF, 1'b1, 1'b0, 3);
    drain();
    chk("sat_cnt_before_clr", 32'(sat_cnt), 1);
    send(32'h44000000, 24'h7FFFFF, 1'b1, 1'b0, 3);
    in_valid = 1'b0;
    @(negedge clk);
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid) chk("clr_wait_timeout", 32'(out_valid), 1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    chk("sat_cnt_clr_priority", 32'(sat_cnt), 0);
    chk("sb_empty_end", 32'(sb.size()), 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
